bpsk_ram_arbiter: RTL and testbench
===================================

// Module: bpsk_ram_arbiter
// PURPOSE
//  Shares the single port-B of the BPSK symbol BRAM (blk_mem_gen, 8b addr, 8b data) between two requesters:
//  the modulator phase controller (read-only, latency-critical) and a host frame loader (read/write).
//  Sits between Phase_Ctrl / loader and the BRAM; owns ram_clk/ram_en/ram_we/ram_addr/ram_wr_data/ram_rst.
//  Modulator has priority; an anti-starvation counter guarantees the loader a slot.
// PARAMETERS
//  ADDR_W      8   BRAM address width
//  DATA_W      8   BRAM data width
//  RD_LAT      1   BRAM read latency in cycles from ram_en to valid ram_rd_data (1..3)
//  STARVE_MAX  4   consecutive lost cycles of a pending host request before host is forced through (>=1)
// PORTS
//  clk          in   1       system clock (100 MHz)
//  rst_n        in   1       asynchronous active-low reset
//  m_req        in   1       modulator read request, held until m_gnt
//  m_addr       in   ADDR_W  modulator read address
//  m_gnt        out  1       modulator request accepted this cycle
//  m_rdata      out  DATA_W  modulator read data
//  m_rvld       out  1       m_rdata valid (one-cycle pulse per accepted read)
//  h_req        in   1       host request, held until h_gnt
//  h_we         in   1       host request is write (1) / read (0)
//  h_addr       in   ADDR_W  host address
//  h_wdata      in   DATA_W  host write data
//  h_gnt        out  1       host request accepted this cycle
//  h_rdata      out  DATA_W  host read data
//  h_rvld       out  1       h_rdata valid (reads only)
//  ram_clk      out  1       BRAM clock, = clk
//  ram_en       out  1       BRAM enable
//  ram_we       out  1       BRAM write enable
//  ram_addr     out  ADDR_W  BRAM address
//  ram_wr_data  out  DATA_W  BRAM write data
//  ram_rd_data  in   DATA_W  BRAM read data
//  ram_rst      out  1       BRAM reset, active-high
//  stat_coll    out  16      collision counter (see CONFIGURATION)
//  stat_force   out  16      forced-host-grant counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: all outputs 0 except ram_rst=1; starve_cnt=0; tag pipe cleared. ram_rst drops on first clk edge after rst_n release.
//  - Handshake: request accepted on a rising edge where req&gnt=1; gnt is combinational from req and starve_cnt; one access/cycle.
//  - Arbitration: only m_req -> m_gnt; only h_req -> h_gnt; both -> m_gnt unless starve_cnt==STARVE_MAX, then h_gnt.
//  - starve_cnt: +1 each cycle h_req high and h_gnt low (saturates at STARVE_MAX); cleared on host acceptance or h_req low.
//  - RAM drive registered: access accepted at edge k drives ram_en=1 (ram_we=h_we for host, 0 for modulator), addr, wdata during cycle k..k+1; idle cycles ram_en=0, ram_we=0.
//  - Read return: owner tag enters RD_LAT+1 deep pipe; m_rvld/h_rvld pulse exactly RD_LAT+1 cycles after the accepting edge; m_rdata/h_rdata = ram_rd_data when the matching rvld is high, hold last value otherwise.
//  - Writes produce no rvld. Back-to-back accepted reads give back-to-back rvld pulses, no bubbles.
//  - Read-after-write same address, consecutive cycles: read returns new data (BRAM write-first mode required).
//  - Reset mid-operation: in-flight reads discarded, no rvld emitted after reset release for pre-reset requests.
//  - Address/data are never modified; no wrap logic here (requesters own addressing).
// CONFIGURATION
//  Macro ARB_STATS_EN:
//  - defined: stat_coll +1 each cycle m_req&h_req both high; stat_force +1 each forced host grant; both saturate at 16'hFFFF, reset to 0.
//  - undefined: counters not built, stat_coll/stat_force tied to 0.
// STRUCTURE
//  - Package bpsk_ram_pkg: ADDR_W/DATA_W defaults, owner tag typedef (TAG_NONE/TAG_MOD/TAG_HOST), STARVE_MAX default.
//  - Sub-module rd_tag_pipe: RD_LAT+1 deep shift register of owner tags, outputs m_rvld/h_rvld; async active-low reset.
//  - Arbiter, starvation counter, RAM drive registers, stats in top level.
// TESTING
//  - Host writes 0xA5 @0x10 then reads @0x10, modulator idle -> ram_we=1 one cycle, h_rvld RD_LAT+1 after read accept, h_rdata=0xA5.
//  - m_req and h_req held high continuously, STARVE_MAX=4 -> grant pattern 4x modulator, 1x host, repeating; stat_force increments per host grant.
//  - Modulator reads 0x00..0xFF back-to-back after host fill with addr^0x3C -> 256 consecutive m_rvld pulses, data matches, no host rvld.
//  - rst_n pulsed low with 2 reads in flight -> outputs return to reset values asynchronously, ram_rst=1, no rvld after release.
//  - Host write 0x77 @0x20 and modulator read @0x20 next cycle -> m_rdata=0x77.
//  - ARB_STATS_EN undefined build, simultaneous requests -> stat_coll stays 0.

Source files
------------

// File: rtl/bpsk_ram_pkg.sv
// -----------------------------------------------------------------------------
// bpsk_ram_pkg
// Shared definitions for the BPSK symbol BRAM port-B arbiter:
//   - default BRAM geometry, read latency and host starvation limit
//   - owner tag carried alongside each in-flight read
//   - saturating 16-bit increment used by the statistics counters
// -----------------------------------------------------------------------------
package bpsk_ram_pkg;

    localparam int ADDR_W_DEF     = 8;
    localparam int DATA_W_DEF     = 8;
    localparam int RD_LAT_DEF     = 1;
    localparam int STARVE_MAX_DEF = 4;

    // Who owns the read whose data will come back from the BRAM
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_MOD  = 2'd1,
        TAG_HOST = 2'd2
    } owner_tag_e;

    // Increment that sticks at all-ones instead of wrapping
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        logic [15:0] r;
        if (v == 16'hFFFF) begin
            r = v;
        end else begin
            r = v + 16'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bpsk_ram_arbiter_rd_tag_pipe.sv
// -----------------------------------------------------------------------------
// rd_tag_pipe
// Delay line of owner tags that lines each accepted read up with the cycle in
// which its data is on ram_rd_data, then turns that into registered valid
// pulses for the modulator and the host.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (clears all stages,
//                   so reads in flight at reset never produce a pulse)
//   tag_in          owner of the access being launched this cycle
//   m_cap / h_cap   last stage holds a modulator / host read: ram_rd_data is
//                   valid now and should be captured at the next edge
//   m_rvld / h_rvld registered one-cycle valid pulses
// -----------------------------------------------------------------------------
module rd_tag_pipe
    import bpsk_ram_pkg::*;
#(
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] tag_in,
    output logic       m_cap,
    output logic       h_cap,
    output logic       m_rvld,
    output logic       h_rvld
);

    // Stage 0 is loaded on the accepting edge together with the RAM drive
    // registers; stage RD_LAT is therefore loaded on the edge at which the
    // BRAM presents the data.
    localparam int DEPTH = RD_LAT + 1;

    logic [DEPTH-1:0][1:0] tag_q;
    logic [DEPTH-1:0][1:0] tag_d;
    logic                  m_rvld_q;
    logic                  m_rvld_d;
    logic                  h_rvld_q;
    logic                  h_rvld_d;

    // Shift the owner tags one stage per cycle
    always_comb begin
        tag_d    = tag_q;
        tag_d[0] = tag_in;
        for (int i = 1; i < DEPTH; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    assign m_cap = (tag_q[DEPTH-1] == TAG_MOD);
    assign h_cap = (tag_q[DEPTH-1] == TAG_HOST);

    // Valid pulses follow the capture decode by one register
    always_comb begin
        m_rvld_d = m_cap;
        h_rvld_d = h_cap;
    end

    // Tag stages and valid registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q    <= {DEPTH{2'b00}};
            m_rvld_q <= 1'b0;
            h_rvld_q <= 1'b0;
        end else begin
            tag_q    <= tag_d;
            m_rvld_q <= m_rvld_d;
            h_rvld_q <= h_rvld_d;
        end
    end

    assign m_rvld = m_rvld_q;
    assign h_rvld = h_rvld_q;

endmodule

// File: rtl/bpsk_ram_arbiter.sv
// -----------------------------------------------------------------------------
// bpsk_ram_arbiter
// Shares port B of the BPSK symbol BRAM between the modulator phase
// controller (read-only, priority) and the host frame loader (read/write).
// A host request that keeps losing to the modulator is forced through once it
// has lost STARVE_MAX consecutive cycles.
// Ports:
//   clk, rst_n                      system clock, async active-low reset
//   m_req/m_addr/m_gnt              modulator read request / grant
//   m_rdata/m_rvld                  modulator read return
//   h_req/h_we/h_addr/h_wdata/h_gnt host request / grant
//   h_rdata/h_rvld                  host read return (reads only)
//   ram_clk/ram_en/ram_we/ram_addr/ram_wr_data/ram_rst   BRAM drive
//   ram_rd_data                     BRAM read data (write-first mode)
//   stat_coll/stat_force            collision / forced-host-grant counters
// Build option:
//   ARB_STATS_EN  when defined, stat_coll and stat_force are real saturating
//                 counters; otherwise both are tied to zero.
// -----------------------------------------------------------------------------
module bpsk_ram_arbiter
    import bpsk_ram_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RD_LAT     = RD_LAT_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m_req,
    input  logic [ADDR_W-1:0] m_addr,
    output logic              m_gnt,
    output logic [DATA_W-1:0] m_rdata,
    output logic              m_rvld,
    input  logic              h_req,
    input  logic              h_we,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic [DATA_W-1:0] h_rdata,
    output logic              h_rvld,
    output logic              ram_clk,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data,
    output logic              ram_rst,
    output logic [15:0]       stat_coll,
    output logic [15:0]       stat_force
);

    localparam int              SC_W       = $clog2(STARVE_MAX + 1);
    localparam logic [SC_W-1:0] STARVE_LIM = SC_W'(STARVE_MAX);

    logic [SC_W-1:0]   starve_cnt_q;
    logic [SC_W-1:0]   starve_cnt_d;
    logic              force_host_s;

    logic              ram_en_q;
    logic              ram_en_d;
    logic              ram_we_q;
    logic              ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [ADDR_W-1:0] ram_addr_d;
    logic [DATA_W-1:0] ram_wr_data_q;
    logic [DATA_W-1:0] ram_wr_data_d;
    logic              ram_rst_q;
    logic              ram_rst_d;

    logic [DATA_W-1:0] m_rdata_q;
    logic [DATA_W-1:0] m_rdata_d;
    logic [DATA_W-1:0] h_rdata_q;
    logic [DATA_W-1:0] h_rdata_d;

    logic [1:0]        tag_in_s;
    logic              m_cap_s;
    logic              h_cap_s;

    // Grant decode: modulator wins unless the pending host request has
    // already lost STARVE_MAX cycles in a row. Nothing is granted while the
    // block is held in reset.
    always_comb begin
        force_host_s = h_req & (starve_cnt_q == STARVE_LIM);
        m_gnt        = rst_n & m_req & ~force_host_s;
        h_gnt        = rst_n & h_req & (~m_req | force_host_s);
    end

    // Consecutive-loss count for the pending host request
    always_comb begin
        if (!h_req) begin
            starve_cnt_d = {SC_W{1'b0}};
        end else if (h_gnt) begin
            starve_cnt_d = {SC_W{1'b0}};
        end else if (starve_cnt_q != STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + SC_W'(1);
        end else begin
            starve_cnt_d = starve_cnt_q;
        end
    end

    // Next BRAM drive and owner tag for the access accepted at this edge.
    // Address and write data hold their last value on idle cycles to avoid
    // needless toggling on the BRAM pins.
    always_comb begin
        ram_en_d      = 1'b0;
        ram_we_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_wr_data_d = ram_wr_data_q;
        tag_in_s      = TAG_NONE;
        if (m_gnt) begin
            ram_en_d   = 1'b1;
            ram_addr_d = m_addr;
            tag_in_s   = TAG_MOD;
        end else if (h_gnt) begin
            ram_en_d   = 1'b1;
            ram_we_d   = h_we;
            ram_addr_d = h_addr;
            if (h_we) begin
                ram_wr_data_d = h_wdata;
                tag_in_s      = TAG_NONE;
            end else begin
                tag_in_s      = TAG_HOST;
            end
        end else begin
            ram_en_d = 1'b0;
        end
    end

    // Read data capture; each return port holds its last value between pulses
    always_comb begin
        m_rdata_d = m_cap_s ? ram_rd_data : m_rdata_q;
        h_rdata_d = h_cap_s ? ram_rd_data : h_rdata_q;
        ram_rst_d = 1'b0;
    end

    // Arbiter state, BRAM drive and read-return registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q  <= {SC_W{1'b0}};
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= {ADDR_W{1'b0}};
            ram_wr_data_q <= {DATA_W{1'b0}};
            ram_rst_q     <= 1'b1;
            m_rdata_q     <= {DATA_W{1'b0}};
            h_rdata_q     <= {DATA_W{1'b0}};
        end else begin
            starve_cnt_q  <= starve_cnt_d;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
            ram_rst_q     <= ram_rst_d;
            m_rdata_q     <= m_rdata_d;
            h_rdata_q     <= h_rdata_d;
        end
    end

    rd_tag_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_tag_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .tag_in (tag_in_s),
        .m_cap  (m_cap_s),
        .h_cap  (h_cap_s),
        .m_rvld (m_rvld),
        .h_rvld (h_rvld)
    );

`ifdef ARB_STATS_EN
    logic [15:0] stat_coll_q;
    logic [15:0] stat_coll_d;
    logic [15:0] stat_force_q;
    logic [15:0] stat_force_d;

    // Collision and forced-grant counters; a host grant while the modulator
    // is also requesting can only be a forced one
    always_comb begin
        if (m_req & h_req) begin
            stat_coll_d = sat_inc16(stat_coll_q);
        end else begin
            stat_coll_d = stat_coll_q;
        end
        if (m_req & h_gnt) begin
            stat_force_d = sat_inc16(stat_force_q);
        end else begin
            stat_force_d = stat_force_q;
        end
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_coll_q  <= 16'h0000;
            stat_force_q <= 16'h0000;
        end else begin
            stat_coll_q  <= stat_coll_d;
            stat_force_q <= stat_force_d;
        end
    end

    assign stat_coll  = stat_coll_q;
    assign stat_force = stat_force_q;
`else
    assign stat_coll  = 16'h0000;
    assign stat_force = 16'h0000;
`endif

    assign ram_clk     = clk;
    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wr_data = ram_wr_data_q;
    assign ram_rst     = ram_rst_q;
    assign m_rdata     = m_rdata_q;
    assign h_rdata     = h_rdata_q;

endmodule

// File: tb/tb_bpsk_ram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bpsk_ram_arbiter
// Drives directed and random traffic into bpsk_ram_arbiter with a write-first
// BRAM model attached, and compares every cycle against a transaction-level
// model: grants from a loss counter, RAM drive from the last accepted
// request, read returns from a queue of (due cycle, owner, data) records and
// a shadow memory.
// -----------------------------------------------------------------------------
module tb_bpsk_ram_arbiter;
    import bpsk_ram_pkg::*;

    localparam int RD_LAT     = 1;
    localparam int STARVE_MAX = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_req = 1'b0;
    logic [7:0] m_addr = 8'h00;
    logic       m_gnt;
    logic [7:0] m_rdata;
    logic       m_rvld;
    logic       h_req = 1'b0;
    logic       h_we = 1'b0;
    logic [7:0] h_addr = 8'h00;
    logic [7:0] h_wdata = 8'h00;
    logic       h_gnt;
    logic [7:0] h_rdata;
    logic       h_rvld;
    logic       ram_clk;
    logic       ram_en;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wr_data;
    logic [7:0] ram_rd_data;
    logic       ram_rst;
    logic [15:0] stat_coll;
    logic [15:0] stat_force;

    int checks = 0;
    int errors = 0;

    bpsk_ram_arbiter #(
        .ADDR_W     (8),
        .DATA_W     (8),
        .RD_LAT     (RD_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .m_req       (m_req),
        .m_addr      (m_addr),
        .m_gnt       (m_gnt),
        .m_rdata     (m_rdata),
        .m_rvld      (m_rvld),
        .h_req       (h_req),
        .h_we        (h_we),
        .h_addr      (h_addr),
        .h_wdata     (h_wdata),
        .h_gnt       (h_gnt),
        .h_rdata     (h_rdata),
        .h_rvld      (h_rvld),
        .ram_clk     (ram_clk),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wr_data (ram_wr_data),
        .ram_rd_data (ram_rd_data),
        .ram_rst     (ram_rst),
        .stat_coll   (stat_coll),
        .stat_force  (stat_force)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out at %0t", name, $time);
    endtask

    // ---------------- write-first BRAM model, RD_LAT cycles ----------------
    logic [7:0] bram [256];
    logic [7:0] rd_pipe [RD_LAT];

    initial begin
        for (int i = 0; i < 256; i++) bram[i] = 8'h00;
        for (int i = 0; i < RD_LAT; i++) rd_pipe[i] = 8'h00;
    end

    always @(posedge ram_clk) begin
        if (ram_en) begin
            if (ram_we) begin
                bram[ram_addr] <= ram_wr_data;
                rd_pipe[0]     <= ram_wr_data;
            end else begin
                rd_pipe[0]     <= bram[ram_addr];
            end
        end
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rd_data = rd_pipe[RD_LAT-1];

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        int         due;
        bit         host;
        logic [7:0] data;
    } ret_t;

    ret_t       rq[$];
    logic [7:0] shadow [256];
    int         cyc = 0;
    int         losses = 0;
    bit         rst_prev = 1'b1;
    bit         e_en = 1'b0;
    bit         e_we = 1'b0;
    logic [7:0] e_addr = 8'h00;
    logic [7:0] e_wdata = 8'h00;
    logic [7:0] e_m_rdata = 8'h00;
    logic [7:0] e_h_rdata = 8'h00;
    int         e_coll = 0;
    int         e_force = 0;
    int         m_rv_cnt = 0;
    int         h_rv_cnt = 0;

    initial begin
        for (int i = 0; i < 256; i++) shadow[i] = 8'h00;
    end

    // Compare on the falling edge: inputs are stable and equal to what the
    // next rising edge will sample.
    always @(negedge clk) begin
        bit em;
        bit eh;
        bit egm;
        bit egh;
        bit both;
        cyc++;
        if (m_rvld) m_rv_cnt++;
        if (h_rvld) h_rv_cnt++;
        if (!rst_n) begin
            chk("rst_m_gnt", m_gnt, 0);
            chk("rst_h_gnt", h_gnt, 0);
            chk("rst_m_rvld", m_rvld, 0);
            chk("rst_h_rvld", h_rvld, 0);
            chk("rst_m_rdata", m_rdata, 0);
            chk("rst_h_rdata", h_rdata, 0);
            chk("rst_ram_en", ram_en, 0);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_ram_addr", ram_addr, 0);
            chk("rst_ram_wr_data", ram_wr_data, 0);
            chk("rst_ram_rst", ram_rst, 1);
            chk("rst_stat_coll", stat_coll, 0);
            chk("rst_stat_force", stat_force, 0);
            rq.delete();
            losses    = 0;
            rst_prev  = 1'b1;
            e_en      = 1'b0;
            e_we      = 1'b0;
            e_m_rdata = 8'h00;
            e_h_rdata = 8'h00;
            e_coll    = 0;
            e_force   = 0;
        end else begin
            chk("ram_rst", ram_rst, rst_prev);
            rst_prev = 1'b0;
            chk("ram_en", ram_en, e_en);
            chk("ram_we", ram_we, e_we);
            if (e_en) chk("ram_addr", ram_addr, e_addr);
            if (e_we) chk("ram_wr_data", ram_wr_data, e_wdata);

            em = 1'b0;
            eh = 1'b0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                if (rq[0].host) begin
                    eh = 1'b1;
                    e_h_rdata = rq[0].data;
                end else begin
                    em = 1'b1;
                    e_m_rdata = rq[0].data;
                end
                void'(rq.pop_front());
            end
            chk("m_rvld", m_rvld, em);
            chk("h_rvld", h_rvld, eh);
            chk("m_rdata", m_rdata, e_m_rdata);
            chk("h_rdata", h_rdata, e_h_rdata);
`ifdef ARB_STATS_EN
            chk("stat_coll", stat_coll, e_coll);
            chk("stat_force", stat_force, e_force);
`else
            chk("stat_coll", stat_coll, 0);
            chk("stat_force", stat_force, 0);
`endif
            both = m_req && h_req;
            egm  = m_req && !(h_req && losses >= STARVE_MAX);
            egh  = h_req && (!m_req || losses >= STARVE_MAX);
            chk("m_gnt", m_gnt, egm);
            chk("h_gnt", h_gnt, egh);

            // effects of the acceptance at the coming rising edge
            e_en = egm || egh;
            e_we = egh && h_we;
            if (egm) begin
                e_addr = m_addr;
                rq.push_back(ret_t'{cyc + RD_LAT + 2, 1'b0, shadow[m_addr]});
            end else if (egh) begin
                e_addr = h_addr;
                if (h_we) begin
                    e_wdata        = h_wdata;
                    shadow[h_addr] = h_wdata;
                end else begin
                    rq.push_back(ret_t'{cyc + RD_LAT + 2, 1'b1, shadow[h_addr]});
                end
            end
            if (h_req && !egh) losses = (losses < STARVE_MAX) ? losses + 1 : losses;
            else losses = 0;
            if (both && e_coll < 65535) e_coll++;
            if (both && egh && e_force < 65535) e_force++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic host_op(input logic we, input logic [7:0] a, input logic [7:0] d);
        bit got;
        got = 1'b0;
        @(posedge clk); #1;
        h_req = 1'b1; h_we = we; h_addr = a; h_wdata = d;
        for (int t = 0; t < 50 && !got; t++) begin
            @(negedge clk);
            got = h_gnt;
        end
        @(posedge clk); #1;
        h_req = 1'b0;
        if (!got) timeout("host_op_gnt");
    endtask

    initial begin
        int i;
        int t;
        int c0;
        int c1;
        bit g;
        logic [15:0] s_coll0;
        logic [15:0] s_force0;
        bit rec [15];

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("pin_ram_rst_after_release", ram_rst, 1);
        @(posedge clk); #1;
        chk("pin_ram_rst_dropped", ram_rst, 0);

        // host write 0xA5 @0x10, then read it back
        host_op(1'b1, 8'h10, 8'hA5);
        c0 = h_rv_cnt;
        host_op(1'b0, 8'h10, 8'h00);
        repeat (RD_LAT + 3) @(posedge clk);
        #1;
        chk("pin_h_rdata_a5", h_rdata, 32'hA5);
        chk("pin_h_rvld_count", h_rv_cnt - c0, 1);

        // both requesting continuously: 4 modulator grants then 1 host grant
        @(posedge clk); #1;
        m_req = 1'b1; m_addr = 8'h01; h_req = 1'b1; h_we = 1'b0; h_addr = 8'h02;
        s_coll0 = stat_coll; s_force0 = stat_force;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            rec[k] = h_gnt && !m_gnt;
        end
        @(posedge clk); #1;
        m_req = 1'b0; h_req = 1'b0;
        for (int k = 0; k < 15; k++) chk("pin_starve_pattern", rec[k], (k % 5) == 4);
`ifdef ARB_STATS_EN
        chk("pin_stat_force_delta", stat_force - s_force0, 3);
        chk("pin_stat_coll_delta", stat_coll - s_coll0, 15);
`else
        chk("pin_stat_coll_off", stat_coll, 0);
        chk("pin_stat_force_off", stat_force, 0);
`endif
        repeat (RD_LAT + 3) @(posedge clk);

        // host fills the whole RAM with addr^0x3C, back-to-back
        #1;
        h_req = 1'b1; h_we = 1'b1; h_addr = 8'h00; h_wdata = 8'h3C;
        i = 0; t = 0;
        while (i < 256 && t < 2000) begin
            @(negedge clk); t++; g = h_gnt;
            @(posedge clk); #1;
            if (g) begin
                i++;
                h_addr  = i[7:0];
                h_wdata = i[7:0] ^ 8'h3C;
            end
        end
        h_req = 1'b0;
        if (i < 256) timeout("host_fill");

        // modulator reads every address back-to-back
        c0 = m_rv_cnt; c1 = h_rv_cnt;
        m_req = 1'b1; m_addr = 8'h00;
        i = 0; t = 0;
        while (i < 256 && t < 2000) begin
            @(negedge clk); t++; g = m_gnt;
            @(posedge clk); #1;
            if (g) begin
                i++;
                m_addr = i[7:0];
            end
        end
        m_req = 1'b0;
        if (i < 256) timeout("mod_sweep");
        repeat (RD_LAT + 3) @(posedge clk);
        #1;
        chk("pin_mod_sweep_rvld", m_rv_cnt - c0, 256);
        chk("pin_mod_sweep_no_host", h_rv_cnt - c1, 0);
        chk("pin_mod_last_data", m_rdata, 32'hFF ^ 32'h3C);

        // host write then modulator read of the same address next cycle
        @(posedge clk); #1;
        h_req = 1'b1; h_we = 1'b1; h_addr = 8'h20; h_wdata = 8'h77;
        @(posedge clk); #1;
        h_req = 1'b0; m_req = 1'b1; m_addr = 8'h20;
        @(posedge clk); #1;
        m_req = 1'b0;
        repeat (RD_LAT + 3) @(posedge clk);
        #1;
        chk("pin_raw_m_rdata", m_rdata, 32'h77);

        // random traffic, requests held until granted
        for (int k = 0; k < 400; k++) begin
            bit ma;
            bit ha;
            @(negedge clk);
            ma = m_gnt; ha = h_gnt;
            @(posedge clk); #1;
            if (!m_req || ma) begin
                m_req  = ($urandom_range(0, 2) != 0);
                m_addr = 8'($urandom_range(0, 15));
            end
            if (!h_req || ha) begin
                h_req   = ($urandom_range(0, 1) != 0);
                h_we    = ($urandom_range(0, 1) != 0);
                h_addr  = 8'($urandom_range(0, 15));
                h_wdata = 8'($urandom);
            end
        end
        @(posedge clk); #1;
        m_req = 1'b0; h_req = 1'b0;
        repeat (RD_LAT + 4) @(posedge clk);

        // reset with two modulator reads in flight
        #1;
        m_req = 1'b1; m_addr = 8'h05;
        @(posedge clk); #1;
        m_addr = 8'h06;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("pin_async_ram_rst", ram_rst, 1);
        chk("pin_async_ram_en", ram_en, 0);
        chk("pin_async_m_gnt", m_gnt, 0);
        chk("pin_async_m_rdata", m_rdata, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1; m_req = 1'b0;
        c0 = m_rv_cnt + h_rv_cnt;
        repeat (8) @(posedge clk);
        #1;
        chk("pin_no_rvld_after_reset", m_rv_cnt + h_rv_cnt - c0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
